// File: rtl/sound_cmd_sched.sv
// sound_cmd_sched
// Queues 7-bit sound commands from the main CPU and presents them one at a
// time on the sound board RIOT port A input. Each command is framed by an
// active-low strobe on PA7, which the RIOT edge detector turns into an
// interrupt. The command is held until the sound CPU reads port A.
//
// Optional feature macro: SOUND_CMD_TIMEOUT_EN
//   defined   : WAIT_ACK gives up after ACK_TIMEOUT CE ticks and pulses TIMEOUT
//   undefined : WAIT_ACK waits for ACK (or RESET) forever, TIMEOUT is 0
//
// Ports
//   CLK, RESET        single clock, synchronous active-high reset
//   CE                PHI2-rate tick; FSM and counters advance only on CE
//   CMD_WR, CMD_D     main-CPU command write (one CLK wide, not gated by CE)
//   CMD_FULL          registered FIFO-full flag
//   CMD_PEND          FIFO non-empty or a command in progress
//   OVERRUN           sticky, set when a write is dropped
//   TIMEOUT           one-CLK pulse when a command is abandoned
//   RIOT_CS/RS_N/R_W/A  sound-bus RIOT access, used to detect the port A read
//   PA_DRV            value driven into RIOT PA_I; [7] strobe, [6:0] command
//
// States
//   IDLE     | nothing in flight, PA7 high; pops the FIFO when non-empty
//   LOAD     | command on PA[6:0], PA7 still high for one CE tick
//   STROBE   | PA7 low for STROBE_CYCLES CE ticks
//   WAIT_ACK | PA7 high, waiting for the sound CPU to read port A

module sound_cmd_sched #(
  parameter int DEPTH_LOG2    = 2,
  parameter int STROBE_CYCLES = 8,
  parameter int ACK_TIMEOUT   = 4096
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       CMD_WR,
  input  logic [6:0] CMD_D,
  output logic       CMD_FULL,
  output logic       CMD_PEND,
  output logic       OVERRUN,
  output logic       TIMEOUT,
  input  logic       RIOT_CS,
  input  logic       RIOT_RS_N,
  input  logic       RIOT_R_W,
  input  logic [2:0] RIOT_A,
  output logic [7:0] PA_DRV
);

  localparam int                  DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE     = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [7:0]          STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [15:0]         TO_LAST     = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_STROBE   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [6:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  full_q;
  logic                  overrun_q;

  // FSM registers
  state_t                state_q;
  logic [7:0]            pa_q;
  logic [7:0]            scnt_q;
  logic                  ack_seen_q;
  logic                  timeout_q;

  logic ack;
  logic pop;
  logic push;

  // Only a CE-qualified read of port A data (RS_N=1, A=000) acknowledges.
  assign ack  = CE & RIOT_CS & RIOT_RS_N & RIOT_R_W & (RIOT_A == 3'b000);
  assign pop  = CE && (state_q == ST_IDLE) && (count_q != '0);
  // A pop on the same edge frees the slot, so a write to a full FIFO is kept.
  assign push = CMD_WR && ((count_q != CNT_DEPTH) || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= CMD_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_DEPTH);
      if (CMD_WR && !push) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef SOUND_CMD_TIMEOUT_EN
  logic [15:0] tcnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pa_q       <= 8'hFF;
      scnt_q     <= '0;
      ack_seen_q <= 1'b0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      // TIMEOUT lasts one CLK, independent of the CE rate.
      timeout_q <= 1'b0;
      if (CE) begin
        case (state_q)
          ST_IDLE: begin
            if (pop) begin
              state_q    <= ST_LOAD;
              pa_q       <= {1'b1, mem_q[rd_ptr_q]};
              ack_seen_q <= 1'b0;
            end
          end
          ST_LOAD: begin
            state_q <= ST_STROBE;
            pa_q[7] <= 1'b0;
            scnt_q  <= STROBE_LOAD;
            if (ack) begin
              ack_seen_q <= 1'b1;
            end
          end
          ST_STROBE: begin
            if (ack) begin
              ack_seen_q <= 1'b1;
            end
            if (scnt_q == 8'd0) begin
              pa_q[7] <= 1'b1;
              tcnt_q  <= '0;
              // An early read already acknowledged this command.
              state_q <= (ack_seen_q || ack) ? ST_IDLE : ST_WAIT_ACK;
            end else begin
              scnt_q <= scnt_q - 8'd1;
            end
          end
          ST_WAIT_ACK: begin
            // ACK takes priority over expiry on the same tick.
            if (ack) begin
              state_q <= ST_IDLE;
            end else if (tcnt_q == TO_LAST) begin
              state_q   <= ST_IDLE;
              timeout_q <= 1'b1;
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
`else
  // No timeout hardware; keep the parameter referenced so it is not dangling.
  logic unused_to_cfg;
  assign unused_to_cfg = ^TO_LAST;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pa_q       <= 8'hFF;
      scnt_q     <= '0;
      ack_seen_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (CE) begin
        case (state_q)
          ST_IDLE: begin
            if (pop) begin
              state_q    <= ST_LOAD;
              pa_q       <= {1'b1, mem_q[rd_ptr_q]};
              ack_seen_q <= 1'b0;
            end
          end
          ST_LOAD: begin
            state_q <= ST_STROBE;
            pa_q[7] <= 1'b0;
            scnt_q  <= STROBE_LOAD;
            if (ack) begin
              ack_seen_q <= 1'b1;
            end
          end
          ST_STROBE: begin
            if (ack) begin
              ack_seen_q <= 1'b1;
            end
            if (scnt_q == 8'd0) begin
              pa_q[7] <= 1'b1;
              state_q <= (ack_seen_q || ack) ? ST_IDLE : ST_WAIT_ACK;
            end else begin
              scnt_q <= scnt_q - 8'd1;
            end
          end
          ST_WAIT_ACK: begin
            if (ack) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end
`endif

  assign PA_DRV   = pa_q;
  assign CMD_FULL = full_q;
  assign OVERRUN  = overrun_q;
  assign TIMEOUT  = timeout_q;
  assign CMD_PEND = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_cmd_sched.sv
module tb_sound_cmd_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [6:0] cmd_d = '0;
  logic       cmd_full;
  logic       cmd_pend;
  logic       overrun;
  logic       timeout;
  logic       riot_cs = 1'b0;
  logic       riot_rs_n = 1'b0;
  logic       riot_r_w = 1'b0;
  logic [2:0] riot_a = '0;
  logic [7:0] pa_drv;

  int n_cmp = 0;
  int n_err = 0;

  sound_cmd_sched #(
    .DEPTH_LOG2   (2),
    .STROBE_CYCLES(8),
    .ACK_TIMEOUT  (16)
  ) dut (
    .CLK      (clk),
    .RESET    (reset),
    .CE       (ce),
    .CMD_WR   (cmd_wr),
    .CMD_D    (cmd_d),
    .CMD_FULL (cmd_full),
    .CMD_PEND (cmd_pend),
    .OVERRUN  (overrun),
    .TIMEOUT  (timeout),
    .RIOT_CS  (riot_cs),
    .RIOT_RS_N(riot_rs_n),
    .RIOT_R_W (riot_r_w),
    .RIOT_A   (riot_a),
    .PA_DRV   (pa_drv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CE edge: three quiet CLKs then one CLK with CE high; returns at the
  // falling edge after the CE edge, so outputs reflect that edge.
  task automatic ce_tick();
    repeat (3) @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic ce_tick_wr(input logic [6:0] d);
    repeat (3) @(negedge clk);
    ce = 1'b1;
    cmd_wr = 1'b1;
    cmd_d = d;
    @(negedge clk);
    ce = 1'b0;
    cmd_wr = 1'b0;
  endtask

  task automatic wr(input logic [6:0] d);
    cmd_wr = 1'b1;
    cmd_d = d;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic bus(input logic cs, input logic rs_n, input logic r_w, input logic [2:0] a);
    riot_cs = cs;
    riot_rs_n = rs_n;
    riot_r_w = r_w;
    riot_a = a;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_pa", 16'(pa_drv), 16'hFF);
    check("rst_full", 16'(cmd_full), 16'h0);
    check("rst_pend", 16'(cmd_pend), 16'h0);
    check("rst_ovr", 16'(overrun), 16'h0);
    check("rst_to", 16'(timeout), 16'h0);

    // Single command 2A
    wr(7'h2A);
    check("s_pend_wr", 16'(cmd_pend), 16'h1);
    check("s_pa_prewr", 16'(pa_drv), 16'hFF);
    ce_tick();
    check("s_load", 16'(pa_drv), 16'hAA);
    ce_tick();
    check("s_strobe0", 16'(pa_drv), 16'h2A);
    for (int k = 1; k < 8; k++) begin
      ce_tick();
      check("s_strobe", 16'(pa_drv), 16'h2A);
    end
    ce_tick();
    check("s_release", 16'(pa_drv), 16'hAA);
    check("s_wait_pend", 16'(cmd_pend), 16'h1);

    // Non-ACK accesses in WAIT_ACK: RAM read, port-B read, port-A write
    bus(1'b1, 1'b0, 1'b1, 3'b000);
    ce_tick();
    check("nack_ram", 16'(cmd_pend), 16'h1);
    bus(1'b1, 1'b1, 1'b1, 3'b010);
    ce_tick();
    check("nack_pb", 16'(cmd_pend), 16'h1);
    bus(1'b1, 1'b1, 1'b0, 3'b000);
    ce_tick();
    check("nack_pawr", 16'(cmd_pend), 16'h1);
    bus(1'b1, 1'b1, 1'b1, 3'b000);
    ce_tick();
    bus(1'b0, 1'b0, 1'b0, 3'b000);
    check("ack_pend", 16'(cmd_pend), 16'h0);
    check("ack_pa", 16'(pa_drv), 16'hAA);
    check("ack_to", 16'(timeout), 16'h0);

    // Queue ordering with ACK during each strobe; LOADs are 10 CE ticks apart
    wr(7'h01);
    wr(7'h02);
    wr(7'h03);
    check("q_full", 16'(cmd_full), 16'h0);
    for (int i = 0; i < 3; i++) begin
      ce_tick();
      check("q_load", 16'(pa_drv), 16'({1'b1, 7'(i + 1)}));
      bus(1'b1, 1'b1, 1'b1, 3'b000);
      ce_tick();
      bus(1'b0, 1'b0, 1'b0, 3'b000);
      check("q_strobe", 16'(pa_drv), 16'({1'b0, 7'(i + 1)}));
      repeat (7) ce_tick();
      check("q_strobe_end", 16'(pa_drv), 16'({1'b0, 7'(i + 1)}));
      ce_tick();
      check("q_release", 16'(pa_drv), 16'({1'b1, 7'(i + 1)}));
    end
    check("q_pend_done", 16'(cmd_pend), 16'h0);

    // Full and overrun
    wr(7'h10);
    ce_tick();
    check("f_load", 16'(pa_drv), 16'h90);
    wr(7'h11);
    wr(7'h12);
    wr(7'h13);
    check("f_full3", 16'(cmd_full), 16'h0);
    wr(7'h14);
    check("f_full4", 16'(cmd_full), 16'h1);
    check("f_ovr0", 16'(overrun), 16'h0);
    bus(1'b1, 1'b1, 1'b1, 3'b000);
    ce_tick();
    bus(1'b0, 1'b0, 1'b0, 3'b000);
    check("f_strobe", 16'(pa_drv), 16'h10);
    repeat (8) ce_tick();
    check("f_release", 16'(pa_drv), 16'h90);
    ce_tick_wr(7'h15);
    check("f_pop_load", 16'(pa_drv), 16'h91);
    check("f_pop_full", 16'(cmd_full), 16'h1);
    check("f_pop_ovr", 16'(overrun), 16'h0);
    wr(7'h16);
    check("f_drop_ovr", 16'(overrun), 16'h1);
    check("f_drop_full", 16'(cmd_full), 16'h1);

    // Reset mid-strobe
    ce_tick();
    check("r_strobe", 16'(pa_drv), 16'h11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("r_pa", 16'(pa_drv), 16'hFF);
    check("r_pend", 16'(cmd_pend), 16'h0);
    check("r_full", 16'(cmd_full), 16'h0);
    check("r_ovr", 16'(overrun), 16'h0);
    repeat (2) ce_tick();
    check("r_pa_after", 16'(pa_drv), 16'hFF);
    check("r_pend_after", 16'(cmd_pend), 16'h0);

    // ACK in IDLE is not credited to the next command
    bus(1'b1, 1'b1, 1'b1, 3'b000);
    ce_tick();
    bus(1'b0, 1'b0, 1'b0, 3'b000);
    wr(7'h55);
    ce_tick();
    check("i_load", 16'(pa_drv), 16'hD5);
    ce_tick();
    check("i_strobe", 16'(pa_drv), 16'h55);
    repeat (8) ce_tick();
    check("i_release", 16'(pa_drv), 16'hD5);
    check("i_wait_pend", 16'(cmd_pend), 16'h1);

`ifdef SOUND_CMD_TIMEOUT_EN
    // Timeout after 16 CE ticks in WAIT_ACK, then the queued entry loads
    wr(7'h66);
    repeat (15) ce_tick();
    check("t_pre_to", 16'(timeout), 16'h0);
    check("t_pre_pend", 16'(cmd_pend), 16'h1);
    check("t_pre_pa", 16'(pa_drv), 16'hD5);
    ce_tick();
    check("t_pulse", 16'(timeout), 16'h1);
    @(negedge clk);
    check("t_pulse_end", 16'(timeout), 16'h0);
    ce_tick();
    check("t_next_load", 16'(pa_drv), 16'hE6);
    repeat (9) ce_tick();
    check("t_next_wait", 16'(pa_drv), 16'hE6);
    repeat (15) ce_tick();
    bus(1'b1, 1'b1, 1'b1, 3'b000);
    ce_tick();
    bus(1'b0, 1'b0, 1'b0, 3'b000);
    check("t_ack_wins_to", 16'(timeout), 16'h0);
    check("t_ack_wins_pend", 16'(cmd_pend), 16'h0);
    @(negedge clk);
    check("t_ack_wins_to2", 16'(timeout), 16'h0);
`else
    // Without the timeout build WAIT_ACK holds until ACK
    repeat (20) ce_tick();
    check("n_hold_pend", 16'(cmd_pend), 16'h1);
    check("n_hold_to", 16'(timeout), 16'h0);
    check("n_hold_pa", 16'(pa_drv), 16'hD5);
    bus(1'b1, 1'b1, 1'b1, 3'b000);
    ce_tick();
    bus(1'b0, 1'b0, 1'b0, 3'b000);
    check("n_ack_pend", 16'(cmd_pend), 16'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
